// File: rtl/key_round_register.sv
// ----------------------------------------------------------------------------
// key_round_register
//   Produces ROUNDS successive round-key halves (C, D) from one loaded pair.
//   Each round circularly rotates both halves left by 1 or 2 bits, as selected
//   by SHIFT_SCHED.
//   The current round value is offered with valid_o. It advances only on a
//   ready_i handshake. done_o pulses for one cycle after the final round is
//   accepted.
//
//   Optional feature (macro KEY_DECRYPT_EN): adds mode_i, sampled with load_i.
//   When mode_i=1 the rounds are walked in reverse order, from ROUNDS down to
//   1, with right rotations.
//
// Ports
//   clk_i     : clock, rising edge
//   rst_ni    : asynchronous active-low reset
//   load_i    : start request; c_in_i/d_in_i (and mode_i) sampled when accepted
//   mode_i    : (KEY_DECRYPT_EN only) 1 = reverse (decrypt) order
//   c_in_i    : initial C half
//   d_in_i    : initial D half
//   ready_i   : downstream accepts current round value
//   c_out_o   : current round C half (registered)
//   d_out_o   : current round D half (registered)
//   valid_o   : c_out_o/d_out_o/round_o hold a valid round value
//   round_o   : current round, 1..ROUNDS while valid, else 0
//   busy_o    : high while a sequence is running
//   done_o    : one-cycle pulse after the last round is accepted
// ----------------------------------------------------------------------------
module key_round_register #(
    parameter int                HALF_W      = 64,
    parameter int                ROUNDS      = 16,
    parameter logic [ROUNDS-1:0] SHIFT_SCHED = ROUNDS'(16'h8103)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
`ifdef KEY_DECRYPT_EN
    input  logic              mode_i,
`endif
    input  logic [HALF_W-1:0] c_in_i,
    input  logic [HALF_W-1:0] d_in_i,
    input  logic              ready_i,
    output logic [HALF_W-1:0] c_out_o,
    output logic [HALF_W-1:0] d_out_o,
    output logic              valid_o,
    output logic [5:0]        round_o,
    output logic              busy_o,
    output logic              done_o
);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    // Rotation amount of round r (1-based): schedule bit set -> 1, else 2.
    function automatic int shamt(input logic [5:0] r);
        int s = 2;
        for (int i = 0; i < ROUNDS; i++)
            if (r == 6'(i + 1) && SHIFT_SCHED[i]) s = 1;
        return s;
    endfunction

    function automatic logic [HALF_W-1:0] rotl(input logic [HALF_W-1:0] x, input int amt);
        int a = amt % HALF_W;
        if (a == 0) return x;
        return (x << a) | (x >> (HALF_W - a));
    endfunction

    function automatic logic [HALF_W-1:0] rotr(input logic [HALF_W-1:0] x, input int amt);
        return rotl(x, HALF_W - (amt % HALF_W));
    endfunction

    state_t              state_q, state_d;
    logic [HALF_W-1:0]   c_q, c_d, d_q, d_d;
    logic [5:0]          round_q, round_d;
    logic                done_q, done_d;

`ifdef KEY_DECRYPT_EN
    // Net rotation after all rounds. A decrypt load jumps straight to the
    // last round's value.
    function automatic int total_shift();
        int t = 0;
        for (int i = 0; i < ROUNDS; i++) t += SHIFT_SCHED[i] ? 1 : 2;
        return t % HALF_W;
    endfunction
    localparam int TOTAL = total_shift();

    logic dec_q, dec_d;
`else
    logic dec_q;
    assign dec_q = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        d_d     = d_q;
        round_d = round_q;
        done_d  = 1'b0;
`ifdef KEY_DECRYPT_EN
        dec_d   = dec_q;
`endif
        case (state_q)
            S_IDLE: begin
                // ready_i has no effect here; only a load starts a sequence.
                if (load_i) begin
                    state_d = S_RUN;
`ifdef KEY_DECRYPT_EN
                    dec_d = mode_i;
                    if (mode_i) begin
                        c_d     = rotl(c_in_i, TOTAL);
                        d_d     = rotl(d_in_i, TOTAL);
                        round_d = 6'(ROUNDS);
                    end else begin
                        c_d     = rotl(c_in_i, shamt(6'd1));
                        d_d     = rotl(d_in_i, shamt(6'd1));
                        round_d = 6'd1;
                    end
`else
                    c_d     = rotl(c_in_i, shamt(6'd1));
                    d_d     = rotl(d_in_i, shamt(6'd1));
                    round_d = 6'd1;
`endif
                end
            end
            S_RUN: begin
                // load_i is ignored here, even on the final handshake.
                if (ready_i) begin
                    if (!dec_q && round_q < 6'(ROUNDS)) begin
                        c_d     = rotl(c_q, shamt(round_q + 6'd1));
                        d_d     = rotl(d_q, shamt(round_q + 6'd1));
                        round_d = round_q + 6'd1;
                    end else if (dec_q && round_q > 6'd1) begin
                        c_d     = rotr(c_q, shamt(round_q));
                        d_d     = rotr(d_q, shamt(round_q));
                        round_d = round_q - 6'd1;
                    end else begin
                        // Last round accepted. Halves keep their final value.
                        state_d = S_IDLE;
                        round_d = 6'd0;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            c_q     <= '0;
            d_q     <= '0;
            round_q <= 6'd0;
            done_q  <= 1'b0;
`ifdef KEY_DECRYPT_EN
            dec_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            d_q     <= d_d;
            round_q <= round_d;
            done_q  <= done_d;
`ifdef KEY_DECRYPT_EN
            dec_q   <= dec_d;
`endif
        end
    end

    assign c_out_o = c_q;
    assign d_out_o = d_q;
    assign round_o = round_q;
    assign valid_o = (state_q == S_RUN);
    assign busy_o  = (state_q == S_RUN);
    assign done_o  = done_q;

endmodule

// File: tb/tb_key_round_register.sv
// Bench for key_round_register (default parameters). The reference model
// tracks the loaded halves plus the cumulative rotation. It derives each
// expected round value as a single rotation of the loaded data.
module tb_key_round_register;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        load = 1'b0;
    logic        ready = 1'b0;
    logic [63:0] c_in = '0, d_in = '0;
`ifdef KEY_DECRYPT_EN
    logic        mode = 1'b0;
`endif
    logic [63:0] c_out, d_out;
    logic        valid, busy, done;
    logic [5:0]  round;

    int checks = 0;
    int failures = 0;

    logic [15:0] sched = 16'h8103;

    key_round_register dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .load_i  (load),
`ifdef KEY_DECRYPT_EN
        .mode_i  (mode),
`endif
        .c_in_i  (c_in),
        .d_in_i  (d_in),
        .ready_i (ready),
        .c_out_o (c_out),
        .d_out_o (d_out),
        .valid_o (valid),
        .round_o (round),
        .busy_o  (busy),
        .done_o  (done)
    );

    always #5 clk = ~clk;

    function automatic int s(input int r);
        return sched[r-1] ? 1 : 2;
    endfunction

    function automatic logic [63:0] rot(input logic [63:0] x, input int n);
        int a = ((n % 64) + 64) % 64;
        return (a == 0) ? x : ((x << a) | (x >> (64 - a)));
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic        m_act = 1'b0, m_dec = 1'b0, m_done = 1'b0;
    int          m_round = 0, m_cum = 0;
    logic [63:0] m_bc = '0, m_bd = '0, m_c = '0, m_d = '0;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_act = 0; m_dec = 0; m_done = 0; m_round = 0; m_cum = 0;
            m_c = '0; m_d = '0;
        end else begin
            m_done = 0;
            if (!m_act) begin
                if (load) begin
                    m_act = 1; m_bc = c_in; m_bd = d_in;
`ifdef KEY_DECRYPT_EN
                    m_dec = mode;
`else
                    m_dec = 0;
`endif
                    if (m_dec) begin
                        m_round = 16; m_cum = 0;
                        for (int r = 1; r <= 16; r++) m_cum += s(r);
                    end else begin
                        m_round = 1; m_cum = s(1);
                    end
                end
            end else if (ready) begin
                if (!m_dec && m_round < 16) begin
                    m_round++; m_cum += s(m_round);
                end else if (m_dec && m_round > 1) begin
                    m_cum -= s(m_round); m_round--;
                end else begin
                    m_act = 0; m_round = 0; m_done = 1;
                end
            end
            if (m_act) begin
                m_c = rot(m_bc, m_cum);
                m_d = rot(m_bd, m_cum);
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge clk);
        chk("cyc_c",     c_out, m_c);
        chk("cyc_d",     d_out, m_d);
        chk("cyc_valid", 64'(valid), 64'(m_act));
        chk("cyc_busy",  64'(busy),  64'(m_act));
        chk("cyc_round", 64'(round), 64'(m_round));
        chk("cyc_done",  64'(done),  64'(m_done));
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic wait_done(input int bound);
        for (int i = 0; i < bound && !done; i++) step();
        chk("wait_done", 64'(done), 64'd1);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_c", c_out, 64'h0);
        chk("rst_valid", 64'(valid), 64'h0);
        chk("rst_round", 64'(round), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_done", 64'(done), 64'h0);

        // Load on the first edge after reset release; nominal vector.
        rst_n = 1'b1; load = 1'b1; ready = 1'b1;
        c_in = 64'h1; d_in = 64'h8000_0000_0000_0000;
        step();
        load = 1'b0;
        chk("t1_valid", 64'(valid), 64'h1);
        chk("t1_round1", 64'(round), 64'd1);
        chk("t1_c1", c_out, 64'h2);
        chk("t1_d1", d_out, 64'h1);
        for (int r = 2; r <= 16; r++) begin
            step();
            if (r == 3)  chk("t1_c3", c_out, 64'h10);
            if (r == 16) chk("t1_c16", c_out, 64'h1000_0000);
        end
        step();
        chk("t1_done", 64'(done), 64'h1);
        chk("t1_hold_c", c_out, 64'h1000_0000);
        chk("t1_round0", 64'(round), 64'h0);
        step();
        chk("t1_done_end", 64'(done), 64'h0);

        // Stall at round 3.
        load = 1'b1; c_in = 64'h1; d_in = 64'h3;
        step(); load = 1'b0;
        step(); step();
        chk("t2_round3", 64'(round), 64'd3);
        ready = 1'b0;
        repeat (5) begin
            step();
            chk("t2_stall_round", 64'(round), 64'd3);
            chk("t2_stall_c", c_out, 64'h10);
            chk("t2_stall_valid", 64'(valid), 64'h1);
        end
        ready = 1'b1;
        step();
        chk("t2_round4", 64'(round), 64'd4);
        chk("t2_c4", c_out, 64'h40);
        wait_done(40);
        step();

        // Load held high for a whole sequence; c_in changes are not re-sampled.
        load = 1'b1; c_in = 64'hA5;
        step();
        chk("t3_round1", 64'(round), 64'd1);
        for (int k = 2; k <= 16; k++) begin
            c_in = {$urandom, $urandom};
            step();
            chk("t3_no_restart", 64'(round), 64'(k));
        end
        step();
        chk("t3_done", 64'(done), 64'h1);
        chk("t3_idle", 64'(valid), 64'h0);
        step();
        chk("t3_restart", 64'(round), 64'd1);
        chk("t3_restart_v", 64'(valid), 64'h1);
        load = 1'b0;

        // Asynchronous reset at round 7.
        repeat (6) step();
        chk("t4_round7", 64'(round), 64'd7);
        #2 rst_n = 1'b0;
        #1;
        chk("t4_async_c", c_out, 64'h0);
        chk("t4_async_d", d_out, 64'h0);
        chk("t4_async_round", 64'(round), 64'h0);
        chk("t4_async_valid", 64'(valid), 64'h0);
        #2 rst_n = 1'b1;
        repeat (3) begin
            step();
            chk("t4_no_done", 64'(done), 64'h0);
            chk("t4_idle", 64'(valid), 64'h0);
        end
        load = 1'b1; c_in = 64'h8000_0000_0000_0000; d_in = 64'h2;
        step(); load = 1'b0;
        chk("t4_round1", 64'(round), 64'd1);
        chk("t4_c1", c_out, 64'h1);
        chk("t4_d1", d_out, 64'h4);
        wait_done(40);
        step();

        // Random back-pressure; checked by the model only.
        load = 1'b1; c_in = {$urandom, $urandom}; d_in = {$urandom, $urandom};
        step(); load = 1'b0;
        repeat (80) begin
            ready = 1'($urandom_range(0, 1));
            step();
        end
        ready = 1'b1;
        if (valid) wait_done(40);
        step();

`ifdef KEY_DECRYPT_EN
        mode = 1'b1; load = 1'b1; c_in = 64'h1; d_in = 64'h8000_0000_0000_0000;
        step(); load = 1'b0;
        chk("dec_c16", c_out, 64'h1000_0000);
        chk("dec_round16", 64'(round), 64'd16);
        repeat (15) step();
        chk("dec_round1", 64'(round), 64'd1);
        chk("dec_c1", c_out, 64'h2);
        step();
        chk("dec_done", 64'(done), 64'h1);
        mode = 1'b0;
        step();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule

// File: doc/key_round_register.md
KEY_ROUND_REGISTER -- requirements
Module: key_round_register

Interface
REQ-001 Parameter HALF_W, default 64, width of each key half (C and D), legal range >= 2.
REQ-002 Parameter ROUNDS, default 16, number of round keys produced per load, legal range 1..32.
REQ-003 Parameter SHIFT_SCHED, default 16'h8103, ROUNDS bits wide; bit r-1 = 1 means round r rotates by 1, bit r-1 = 0 means round r rotates by 2.
REQ-004 Clk  input  1  single clock; all state changes on rising edge.
REQ-005 Reset_n  input  1  asynchronous, active-low reset.
REQ-006 Load  input  1  start request; C_in/D_in are sampled when accepted.
REQ-007 C_in  input  HALF_W  initial C half.
REQ-008 D_in  input  HALF_W  initial D half.
REQ-009 Ready  input  1  downstream accepts the current round value.
REQ-010 C_out  output  HALF_W  current round C half, registered.
REQ-011 D_out  output  HALF_W  current round D half, registered.
REQ-012 Valid  output  1  C_out/D_out/Round hold a valid round value.
REQ-013 Round  output  6  current round number, 1..ROUNDS while Valid, 0 otherwise.
REQ-014 Busy  output  1  high in state RUN.
REQ-015 Done  output  1  one-cycle pulse after the last round is accepted.

Function
REQ-016 The FSM SHALL have exactly two states: IDLE (Valid=0, Busy=0) and RUN (Valid=1, Busy=1).
REQ-017 In IDLE with Load=1, the next edge SHALL load C_out=rotl(C_in,s(1)) and D_out=rotl(D_in,s(1)), set Round=1, and enter RUN; s(r) is 1 or 2 per SHIFT_SCHED.
REQ-018 Load latency SHALL be exactly one cycle: Valid is high on the cycle after Load is sampled.
REQ-019 In RUN, the values SHALL be held unchanged while Ready=0.
REQ-020 In RUN with Ready=1 and Round<ROUNDS, the next edge SHALL rotate both halves left by s(Round+1) and increment Round.
REQ-021 In RUN with Ready=1 and Round=ROUNDS, the next edge SHALL enter IDLE, clear Valid and Round, pulse Done for one cycle, and hold C_out/D_out at their last values.
REQ-022 Load SHALL be ignored in RUN, including a Load that coincides with the final handshake.
REQ-023 Load SHALL be accepted in the cycle in which Done is high, because that cycle is IDLE.
REQ-024 Ready SHALL be ignored in IDLE.
REQ-025 Rotation SHALL be a modulo-HALF_W circular left rotation of each half independently; C and D bits SHALL never mix.

Reset
REQ-026 Reset_n=0 SHALL immediately, without waiting for a clock edge, force IDLE with C_out=0, D_out=0, Valid=0, Round=0, Busy=0 and Done=0.
REQ-027 Reset_n asserted mid-RUN SHALL abort the sequence; after release the block SHALL wait in IDLE for a new Load.
REQ-028 A Load present on the first edge after Reset_n rises SHALL be accepted.

Configuration
REQ-029 Macro KEY_DECRYPT_EN SHALL, when defined, add input Mode (1 bit), which is sampled together with Load.
REQ-030 With KEY_DECRYPT_EN defined and Mode=1, the Load edge SHALL produce rotl(half,T), where T = sum of s(1..ROUNDS) mod HALF_W, and set Round=ROUNDS.
REQ-031 In that mode, each accepted handshake with Round>1 SHALL rotate both halves right by s(Round) and decrement Round; a handshake at Round=1 SHALL finish as in REQ-021.
REQ-032 With KEY_DECRYPT_EN defined and Mode=0, or with the macro undefined (no Mode port), behaviour SHALL be encrypt-only as in REQ-017..REQ-021.

Verification
REQ-033 Defaults; Load with C_in=64'h1, D_in=64'h8000_0000_0000_0000; Ready=1 -> C_out 2,4,16,... across rounds; round 16 C_out=64'h1000_0000; D_out round 1 = 64'h1; Done pulses on the cycle after round 16.
REQ-034 Ready=0 for 5 cycles at Round=3 -> Round, C_out and D_out remain stable and Valid stays 1; after Ready=1, Round=4 and C_out is rotated by 2.
REQ-035 Load=1 held throughout a full sequence -> no restart mid-sequence; a new sequence starts in the Done cycle with Round=1 on the next cycle.
REQ-036 Reset_n pulsed low between clock edges at Round=7 -> all outputs are 0 immediately; no Done pulse follows; the next Load starts again at Round=1.
REQ-037 KEY_DECRYPT_EN, Mode=1, C_in=64'h1 -> first C_out=64'h1000_0000 with Round=16; the sequence ends with C_out=64'h2 at Round=1.
